tone_sequencer: RTL and testbench
=================================

Name: tone_sequencer

Overview:
- Parametrised successor to the single-scale speaker driver.
- Steps through a configurable-length scale in ascending, descending or true ping-pong order and drives a square wave on the speaker pin.
- On a trigger edge, injects a finite beep burst with programmable count, on-time and off-time.
- Sits between the mode/trigger control logic and the speaker output pin.

Parameters:
- NUM_NOTES, 8, scale entries used (2..8); index 0 is the lowest.
- STEP_CYCLES, 25_000_000, clock cycles per scale step.
- BEEP_NOTE, 57, semitone number played during a beep.
- BEEP_COUNT, 4, beeps per burst (1..15).
- BEEP_ON_CYCLES, 10_000_000, cycles each beep sounds.
- BEEP_OFF_CYCLES, 10_000_000, silent cycles after each beep.
- CNT_W, 32, width of the step and beep timers.

Ports:
- clk_100mHz  in  1  system clock, the only clock.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  2  00 idle, 01 ascending, 10 descending, 11 ping-pong.
- beep_trigger  in  1  level input; its rising edge starts a burst.
- speaker  out  1  square-wave output.
- note_idx  out  3  current scale index.
- busy  out  1  high while a beep burst is active.
- step_pulse  out  1  one-cycle pulse on every scale step.

Behaviour:
- Reset state: speaker=0, note_idx=0, busy=0, step_pulse=0, FSM=IDLE, all counters 0, previous-trigger register 0.
- FSM states:
  - IDLE: silent.
  - SCALE: plays the mode pattern.
  - BEEP_ON: plays BEEP_NOTE.
  - BEEP_OFF: silent.
- FSM transitions:
  - A rising edge of beep_trigger (registered previous value) from IDLE or SCALE goes to BEEP_ON, with busy=1 and beep_cnt=0.
  - This has priority over any mode change in the same cycle.
  - Edges arriving while busy=1 are ignored.
  - BEEP_ON goes to BEEP_OFF after BEEP_ON_CYCLES cycles.
  - BEEP_OFF goes to BEEP_ON after BEEP_OFF_CYCLES cycles if beep_cnt+1 < BEEP_COUNT.
  - Otherwise BEEP_OFF exits, clears busy, and enters SCALE if mode≠00, else IDLE.
  - On exit from a burst, the scale restarts at its start index.
  - IDLE goes to SCALE when mode≠00; SCALE goes to IDLE when mode=00.
- Mode change in SCALE: takes effect the next cycle. The index loads the pattern start (asc/ping-pong: 0, desc: NUM_NOTES-1), the step timer clears, and no step_pulse is issued.
- Step timer: counts 0..STEP_CYCLES-1 in SCALE only. At terminal count it wraps to 0, asserts step_pulse for one cycle and advances the index:
  - Ascending: 0..NUM_NOTES-1, then wraps to 0.
  - Descending: NUM_NOTES-1..0, then wraps to NUM_NOTES-1.
  - Ping-pong: direction flag; the endpoints play once (sequence for 4 notes: 0,1,2,3,2,1,0,1…).
- Scale ROM (registered, 1-cycle latency): semitone numbers 48,50,52,53,55,57,59,60 for indices 0..7.
- Semitone n: octave = n/12, note = n%12.
- Pitch divider by note: 511, 482, 455, 430, 405, 383, 361, 341, 322, 303, 286, 270 for A through G#.
- Tone generator:
  - The note counter reloads from the divider at 0.
  - The octave counter decrements on each note-counter zero and reloads with 255>>octave.
  - speaker toggles when both counters are 0.
  - Half-period = (div+1)·((255>>oct)+1) cycles; semitone 48 gives 512·16 = 8192.
- Tone counters restart:
  - On every note change, 1 cycle after the ROM update.
  - On entering any silent state, where speaker is forced to 0.
- Reset mid-burst or mid-scale returns everything to reset values immediately, with no speaker glitch beyond a forced 0.

Decomposition:
- Shared package: mode encodings, FSM state enum, 12-entry pitch-divider constant table, scale semitone table.
- Sub-module semitone_split: 6-bit semitone to octave and note, combinational divide-by-12.
- Tone counters and FSM stay in the top level.

Test Plan (STEP_CYCLES=16, BEEP_ON=40, BEEP_OFF=20, BEEP_COUNT=3, NUM_NOTES=4):
- Reset release, mode=00 → speaker=0, note_idx=0, busy=0 for 1000 cycles.
- mode=01 → note_idx 0,1,2,3,0, changing every 16 cycles with one step_pulse each. Note 0: speaker half-period 8192 cycles.
- mode=11 → note_idx sequence 0,1,2,3,2,1,0,1; endpoints are never repeated.
- Beep edge during mode=01 → busy=1 for 3·(40+20)=180 cycles, 3 sounding windows of 40 cycles, then note_idx=0 and the scale resumes. A second edge mid-burst changes nothing.
- mode 01→10 mid-step → next cycle note_idx=3, step timer restarts (next step 16 cycles later), no step_pulse at the switch.
- rst_n low during BEEP_ON → speaker=0, busy=0, FSM=IDLE asynchronously; after release it behaves as at power-up.

Source files
------------

// File: rtl/tone_sequencer_pkg.sv
// Shared encodings, FSM states and lookup tables for the tone sequencer.
// Pitch dividers are indexed A=0 .. G#=11; scale entries are semitone numbers.
package tone_sequencer_pkg;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_ASC  = 2'b01;
  localparam logic [1:0] MODE_DESC = 2'b10;
  localparam logic [1:0] MODE_PING = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SCALE    = 2'd1,
    ST_BEEP_ON  = 2'd2,
    ST_BEEP_OFF = 2'd3
  } state_e;

  function automatic logic [8:0] pitch_div(input logic [3:0] note);
    case (note)
      4'd0:    pitch_div = 9'd511;
      4'd1:    pitch_div = 9'd482;
      4'd2:    pitch_div = 9'd455;
      4'd3:    pitch_div = 9'd430;
      4'd4:    pitch_div = 9'd405;
      4'd5:    pitch_div = 9'd383;
      4'd6:    pitch_div = 9'd361;
      4'd7:    pitch_div = 9'd341;
      4'd8:    pitch_div = 9'd322;
      4'd9:    pitch_div = 9'd303;
      4'd10:   pitch_div = 9'd286;
      4'd11:   pitch_div = 9'd270;
      default: pitch_div = 9'd511;
    endcase
  endfunction

  function automatic logic [5:0] scale_semitone(input logic [2:0] idx);
    case (idx)
      3'd0:    scale_semitone = 6'd48;
      3'd1:    scale_semitone = 6'd50;
      3'd2:    scale_semitone = 6'd52;
      3'd3:    scale_semitone = 6'd53;
      3'd4:    scale_semitone = 6'd55;
      3'd5:    scale_semitone = 6'd57;
      3'd6:    scale_semitone = 6'd59;
      3'd7:    scale_semitone = 6'd60;
      default: scale_semitone = 6'd48;
    endcase
  endfunction

  // Higher octaves run the octave counter over fewer note-counter wraps.
  function automatic logic [7:0] octave_reload(input logic [2:0] octave);
    octave_reload = 8'hFF >> octave;
  endfunction

endpackage

// File: rtl/semitone_split.sv
// Combinational divide-by-12 of a 6-bit semitone number into octave and
// note-within-octave (0 = A).
module semitone_split
  import tone_sequencer_pkg::*;
(
  input  logic [5:0] semitone,
  output logic [2:0] octave,
  output logic [3:0] note
);

  // Range compare against multiples of 12; the input never exceeds 63.
  always_comb begin
    if (semitone >= 6'd60) begin
      octave = 3'd5;
      note   = 4'(semitone - 6'd60);
    end else if (semitone >= 6'd48) begin
      octave = 3'd4;
      note   = 4'(semitone - 6'd48);
    end else if (semitone >= 6'd36) begin
      octave = 3'd3;
      note   = 4'(semitone - 6'd36);
    end else if (semitone >= 6'd24) begin
      octave = 3'd2;
      note   = 4'(semitone - 6'd24);
    end else if (semitone >= 6'd12) begin
      octave = 3'd1;
      note   = 4'(semitone - 6'd12);
    end else begin
      octave = 3'd0;
      note   = 4'(semitone);
    end
  end

endmodule

// File: rtl/tone_sequencer.sv
// Scale sequencer with triggered beep bursts driving a square-wave speaker.
// FSM, step/beep timers and the two-stage tone counters live here.
module tone_sequencer
  import tone_sequencer_pkg::*;
#(
  parameter int NUM_NOTES       = 8,
  parameter int STEP_CYCLES     = 25_000_000,
  parameter int BEEP_NOTE       = 57,
  parameter int BEEP_COUNT      = 4,
  parameter int BEEP_ON_CYCLES  = 10_000_000,
  parameter int BEEP_OFF_CYCLES = 10_000_000,
  parameter int CNT_W           = 32
)(
  input  logic       clk_100mHz,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic       beep_trigger,
  output logic       speaker,
  output logic [2:0] note_idx,
  output logic       busy,
  output logic       step_pulse
);

  localparam logic [2:0]       LAST_IDX   = 3'(NUM_NOTES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(BEEP_ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LAST   = CNT_W'(BEEP_OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [4:0]       BEEP_TOTAL = 5'(BEEP_COUNT);
  localparam logic [5:0]       BEEP_SEMI  = 6'(BEEP_NOTE);

  state_e           state_r, state_nxt_s;
  logic             trig_prev_r, trig_rise_s;
  logic [1:0]       mode_r;
  logic             busy_r, step_pulse_r, speaker_r;
  logic [CNT_W-1:0] step_cnt_r, beep_tmr_r;
  logic [3:0]       beep_cnt_r;
  logic [2:0]       note_idx_r, idx_next_s, idx_start_s;
  logic             dir_up_r, dir_next_s;
  logic             scale_load_s, step_run_s;
  logic             beep_start_s, beep_next_s, beep_tmr_clr_s;
  logic [5:0]       rom_semi_r, semi_prev_r, tone_semi_s;
  logic [2:0]       octave_s;
  logic [3:0]       note_s;
  logic [8:0]       note_cnt_r, div_s;
  logic [7:0]       oct_cnt_r, oct_rld_s;
  logic             sounding_s, tone_restart_s;

  assign trig_rise_s = beep_trigger & ~trig_prev_r;
  assign idx_start_s = (mode == MODE_DESC) ? LAST_IDX : 3'd0;
  assign step_run_s  = (state_r == ST_SCALE) && (state_nxt_s == ST_SCALE) && !scale_load_s;

  // Next-state and control strobes; a trigger edge outranks any mode change.
  always_comb begin
    state_nxt_s    = state_r;
    scale_load_s   = 1'b0;
    beep_start_s   = 1'b0;
    beep_next_s    = 1'b0;
    beep_tmr_clr_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (trig_rise_s) begin
          state_nxt_s  = ST_BEEP_ON;
          beep_start_s = 1'b1;
        end else if (mode != MODE_IDLE) begin
          state_nxt_s  = ST_SCALE;
          scale_load_s = 1'b1;
        end else begin
          state_nxt_s  = ST_IDLE;
        end
      end
      ST_SCALE: begin
        if (trig_rise_s) begin
          state_nxt_s  = ST_BEEP_ON;
          beep_start_s = 1'b1;
        end else if (mode == MODE_IDLE) begin
          state_nxt_s  = ST_IDLE;
        end else if (mode != mode_r) begin
          state_nxt_s  = ST_SCALE;
          scale_load_s = 1'b1;
        end else begin
          state_nxt_s  = ST_SCALE;
        end
      end
      ST_BEEP_ON: begin
        if (beep_tmr_r == ON_LAST) begin
          state_nxt_s    = ST_BEEP_OFF;
          beep_tmr_clr_s = 1'b1;
        end else begin
          state_nxt_s    = ST_BEEP_ON;
        end
      end
      ST_BEEP_OFF: begin
        if (beep_tmr_r == OFF_LAST) begin
          beep_tmr_clr_s = 1'b1;
          if (({1'b0, beep_cnt_r} + 5'd1) < BEEP_TOTAL) begin
            state_nxt_s = ST_BEEP_ON;
            beep_next_s = 1'b1;
          end else if (mode != MODE_IDLE) begin
            state_nxt_s  = ST_SCALE;
            scale_load_s = 1'b1;
          end else begin
            state_nxt_s  = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_BEEP_OFF;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Index advance for the current pattern; ping-pong turns at the endpoints.
  always_comb begin
    idx_next_s = note_idx_r;
    dir_next_s = dir_up_r;
    case (mode)
      MODE_ASC:  idx_next_s = (note_idx_r == LAST_IDX) ? 3'd0 : note_idx_r + 3'd1;
      MODE_DESC: idx_next_s = (note_idx_r == 3'd0) ? LAST_IDX : note_idx_r - 3'd1;
      MODE_PING: begin
        if (dir_up_r) begin
          if (note_idx_r == LAST_IDX) begin
            idx_next_s = note_idx_r - 3'd1;
            dir_next_s = 1'b0;
          end else begin
            idx_next_s = note_idx_r + 3'd1;
          end
        end else begin
          if (note_idx_r == 3'd0) begin
            idx_next_s = 3'd1;
            dir_next_s = 1'b1;
          end else begin
            idx_next_s = note_idx_r - 3'd1;
          end
        end
      end
      default: idx_next_s = note_idx_r;
    endcase
  end

  // FSM state, input history and busy flag.
  always_ff @(posedge clk_100mHz or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      trig_prev_r <= 1'b0;
      mode_r      <= MODE_IDLE;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      trig_prev_r <= beep_trigger;
      mode_r      <= mode;
      busy_r      <= (state_nxt_s == ST_BEEP_ON) || (state_nxt_s == ST_BEEP_OFF);
    end
  end

  // Step timer and scale index; a load never emits a step pulse.
  always_ff @(posedge clk_100mHz or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt_r   <= '0;
      note_idx_r   <= 3'd0;
      dir_up_r     <= 1'b1;
      step_pulse_r <= 1'b0;
    end else begin
      step_pulse_r <= 1'b0;
      if (scale_load_s) begin
        step_cnt_r <= '0;
        note_idx_r <= idx_start_s;
        dir_up_r   <= 1'b1;
      end else if (step_run_s) begin
        if (step_cnt_r == STEP_LAST) begin
          step_cnt_r   <= '0;
          step_pulse_r <= 1'b1;
          note_idx_r   <= idx_next_s;
          dir_up_r     <= dir_next_s;
        end else begin
          step_cnt_r <= step_cnt_r + CNT_ONE;
        end
      end else begin
        step_cnt_r <= step_cnt_r;
      end
    end
  end

  // Beep on/off timer and per-burst beep counter.
  always_ff @(posedge clk_100mHz or negedge rst_n) begin
    if (!rst_n) begin
      beep_tmr_r <= '0;
      beep_cnt_r <= 4'd0;
    end else if (beep_start_s) begin
      beep_tmr_r <= '0;
      beep_cnt_r <= 4'd0;
    end else if (beep_next_s) begin
      beep_tmr_r <= '0;
      beep_cnt_r <= beep_cnt_r + 4'd1;
    end else if (beep_tmr_clr_s) begin
      beep_tmr_r <= '0;
    end else if ((state_r == ST_BEEP_ON) || (state_r == ST_BEEP_OFF)) begin
      beep_tmr_r <= beep_tmr_r + CNT_ONE;
    end else begin
      beep_tmr_r <= beep_tmr_r;
    end
  end

  // Registered scale ROM.
  always_ff @(posedge clk_100mHz or negedge rst_n) begin
    if (!rst_n) begin
      rom_semi_r <= 6'd0;
    end else begin
      rom_semi_r <= scale_semitone(note_idx_r);
    end
  end

  assign sounding_s     = (state_r == ST_SCALE) || (state_r == ST_BEEP_ON);
  assign tone_semi_s    = (state_r == ST_BEEP_ON) ? BEEP_SEMI : rom_semi_r;
  assign tone_restart_s = (tone_semi_s != semi_prev_r);
  assign div_s          = pitch_div(note_s);
  assign oct_rld_s      = octave_reload(octave_s);

  semitone_split u_split (
    .semitone (tone_semi_s),
    .octave   (octave_s),
    .note     (note_s)
  );

  // Two-stage tone divider; silent states hold the counters preloaded.
  always_ff @(posedge clk_100mHz or negedge rst_n) begin
    if (!rst_n) begin
      semi_prev_r <= 6'd0;
      note_cnt_r  <= 9'd0;
      oct_cnt_r   <= 8'd0;
      speaker_r   <= 1'b0;
    end else begin
      semi_prev_r <= tone_semi_s;
      if (!sounding_s) begin
        note_cnt_r <= div_s;
        oct_cnt_r  <= oct_rld_s;
        speaker_r  <= 1'b0;
      end else if (tone_restart_s) begin
        note_cnt_r <= div_s;
        oct_cnt_r  <= oct_rld_s;
      end else if (note_cnt_r == 9'd0) begin
        note_cnt_r <= div_s;
        if (oct_cnt_r == 8'd0) begin
          oct_cnt_r <= oct_rld_s;
          speaker_r <= ~speaker_r;
        end else begin
          oct_cnt_r <= oct_cnt_r - 8'd1;
        end
      end else begin
        note_cnt_r <= note_cnt_r - 9'd1;
      end
    end
  end

  assign speaker    = speaker_r;
  assign note_idx   = note_idx_r;
  assign busy       = busy_r;
  assign step_pulse = step_pulse_r;

endmodule

// File: tb/tb_tone_sequencer.sv
// Randomised bench for tone_sequencer against a timeline-based reference model,
// plus a long-step instance for measuring tone half-periods.
module tb_tone_sequencer;

  localparam int N    = 4;
  localparam int STEP = 16;
  localparam int ON   = 40;
  localparam int OFF  = 20;
  localparam int CNT  = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode;
  logic       beep_trigger;
  logic       speaker, busy, step_pulse;
  logic [2:0] note_idx;
  logic [1:0] mode2;
  logic       trig2;
  logic       speaker2, busy2, step_pulse2;
  logic [2:0] note_idx2;

  int n_cmp = 0;
  int n_mis = 0;

  int         t, burst_t0, seg_t0, m_idx;
  bit         m_busy, m_active, m_pulse, prev_trig;
  logic [1:0] seg_mode, prev_mode;
  int         div_tab [12] = '{511, 482, 455, 430, 405, 383, 361, 341, 322, 303, 286, 270};

  always #5 clk = ~clk;

  tone_sequencer #(.NUM_NOTES(N), .STEP_CYCLES(STEP), .BEEP_NOTE(57), .BEEP_COUNT(CNT),
                   .BEEP_ON_CYCLES(ON), .BEEP_OFF_CYCLES(OFF), .CNT_W(32)) dut (
    .clk_100mHz(clk), .rst_n(rst_n), .mode(mode), .beep_trigger(beep_trigger),
    .speaker(speaker), .note_idx(note_idx), .busy(busy), .step_pulse(step_pulse));

  tone_sequencer #(.NUM_NOTES(N), .STEP_CYCLES(30000), .BEEP_NOTE(57), .BEEP_COUNT(1),
                   .BEEP_ON_CYCLES(16000), .BEEP_OFF_CYCLES(20), .CNT_W(32)) dut_tone (
    .clk_100mHz(clk), .rst_n(rst_n), .mode(mode2), .beep_trigger(trig2),
    .speaker(speaker2), .note_idx(note_idx2), .busy(busy2), .step_pulse(step_pulse2));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pattern(input logic [1:0] md, input int k);
    int p;
    int r;
    p = 2 * N - 2;
    r = k % p;
    case (md)
      2'b01:   return k % N;
      2'b10:   return N - 1 - (k % N);
      default: return (r < N) ? r : p - r;
    endcase
  endfunction

  function automatic int half_period(input int semi);
    return (div_tab[semi % 12] + 1) * ((255 >> (semi / 12)) + 1);
  endfunction

  task automatic model_reset();
    t = 0; burst_t0 = 0; seg_t0 = 0; m_idx = 0;
    m_busy = 1'b0; m_active = 1'b0; m_pulse = 1'b0; prev_trig = 1'b0;
    seg_mode = 2'b00; prev_mode = 2'b00;
  endtask

  // One clock edge of the reference timeline with inputs m, g.
  task automatic model_edge(input logic [1:0] m, input logic g);
    int el;
    t++;
    if (m_busy) begin
      if (t - burst_t0 == CNT * (ON + OFF)) begin
        m_busy   = 1'b0;
        m_active = (m != 2'b00);
        seg_t0   = t;
        seg_mode = m;
      end
    end else if (g && !prev_trig) begin
      m_busy   = 1'b1;
      burst_t0 = t;
      m_active = 1'b0;
    end else if (m_active) begin
      if (m == 2'b00) m_active = 1'b0;
      else if (m != prev_mode) begin seg_t0 = t; seg_mode = m; end
    end else if (m != 2'b00) begin
      m_active = 1'b1;
      seg_t0   = t;
      seg_mode = m;
    end
    prev_trig = g;
    prev_mode = m;
    m_pulse   = 1'b0;
    if (m_active) begin
      el      = t - seg_t0;
      m_idx   = pattern(seg_mode, el / STEP);
      m_pulse = (el > 0) && (el % STEP == 0);
    end
  endtask

  // At a falling edge: compare, apply new inputs, advance the model one edge.
  task automatic cycle(input logic [1:0] m, input logic g);
    check_val("note_idx",   32'(note_idx),   32'(m_idx));
    check_val("busy",       32'(busy),       32'(m_busy));
    check_val("step_pulse", 32'(step_pulse), 32'(m_pulse));
    check_val("speaker",    32'(speaker),    32'd0);
    mode = m;
    beep_trigger = g;
    model_edge(m, g);
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] md;
    int         len;
    logic       g;
    logic       last;
    int         tog[$];

    rst_n = 1'b0; mode = 2'b00; beep_trigger = 1'b0; mode2 = 2'b00; trig2 = 1'b0;
    g = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < 1000; i++) cycle(2'b00, 1'b0);
    for (int i = 0; i < 5 * STEP + 4; i++) cycle(2'b01, 1'b0);
    for (int i = 0; i < 8 * STEP + 4; i++) cycle(2'b11, 1'b0);
    for (int i = 0; i < 2; i++)   cycle(2'b01, 1'b1);
    for (int i = 0; i < 60; i++)  cycle(2'b01, 1'b0);
    for (int i = 0; i < 3; i++)   cycle(2'b01, 1'b1);
    for (int i = 0; i < 150; i++) cycle(2'b01, 1'b0);
    for (int i = 0; i < 8; i++)   cycle(2'b01, 1'b0);
    for (int i = 0; i < 40; i++)  cycle(2'b10, 1'b0);

    for (int s = 0; s < 60; s++) begin
      md  = 2'($urandom_range(0, 3));
      len = $urandom_range(4, 70);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 29) == 0) g = ~g;
        cycle(md, g);
      end
    end

    // Asynchronous reset in the middle of a sounding beep.
    for (int i = 0; i < 200; i++) cycle(2'b00, 1'b0);
    for (int i = 0; i < 20; i++)  cycle(2'b01, 1'b1);
    check_val("busy_before_rst", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_speaker",  32'(speaker),    32'd0);
    check_val("rst_busy",     32'(busy),       32'd0);
    check_val("rst_note_idx", 32'(note_idx),   32'd0);
    check_val("rst_pulse",    32'(step_pulse), 32'd0);
    repeat (3) @(negedge clk);
    mode = 2'b00; beep_trigger = 1'b0;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 20; i++) cycle(2'b00, 1'b0);
    for (int i = 0; i < 3 * STEP + 5; i++) cycle(2'b01, 1'b0);
    mode = 2'b00;

    // Tone half-periods on the long-step instance.
    check_val("tone_idle_speaker", 32'(speaker2), 32'd0);
    mode2 = 2'b01;
    last  = speaker2;
    tog.delete();
    for (int c = 1; c <= 28000; c++) begin
      @(negedge clk);
      if (speaker2 !== last) begin tog.push_back(c); last = speaker2; end
    end
    check_val("scale_toggles", 32'(tog.size()), 32'd3);
    for (int i = 1; i < tog.size(); i++)
      check_val("scale_half_period", 32'(tog[i] - tog[i-1]), 32'(half_period(48)));

    trig2 = 1'b1;
    tog.delete();
    for (int c = 1; c <= 16060; c++) begin
      @(negedge clk);
      if (c <= 15990 && speaker2 !== last) tog.push_back(c);
      last = speaker2;
      if (c == 10) check_val("beep_busy", 32'(busy2), 32'd1);
      if (c == 16010) begin
        check_val("beep_off_speaker", 32'(speaker2), 32'd0);
        check_val("beep_off_busy",    32'(busy2),    32'd1);
      end
    end
    check_val("beep_toggles", 32'(tog.size()), 32'd3);
    for (int i = 1; i < tog.size(); i++)
      check_val("beep_half_period", 32'(tog[i] - tog[i-1]), 32'(half_period(57)));
    check_val("after_burst_busy", 32'(busy2),     32'd0);
    check_val("after_burst_idx",  32'(note_idx2), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
